dual_port_router: RTL and testbench
===================================

Name: dual_port_router

Overview:
Router core that sits behind dual_port_router_if and acts as the responder for all three driven planes.
- Accepts bytes on two valid/ready input ports (A, B) and forwards each one to one of four registered outputs, selected by a 2-bit address.
- Contains a simple APB-like control/status register block: enable, output mask, arbitration mode, per-output forward counters and a drop counter.
- This is the DUT the team's Ctrl/Port A/Port B drivers and output monitor connect to.

Parameters:
REG_W, 32, register data width; legal values are 8 to 32. Counters are REG_W bits wide.
NUM_OUT, 4, number of output ports; fixed at 4, parameter kept for the package.

Ports:
clk  input  1  clock; all logic is rising-edge.
rst_n  input  1  asynchronous active-low reset.
reg_addr  input  4  register address.
reg_wdata  input  REG_W  write data.
reg_en  input  1  register access strobe; one access per cycle.
reg_we  input  1  1 = write, 0 = read.
reg_rdata  output  REG_W  read data, registered.
data_a  input  8  port A byte.
addr_a  input  2  port A destination output.
valid_a  input  1  port A valid.
ready_a  output  1  port A ready; combinational.
data_b, addr_b, valid_b  input  8/2/1  port B, same meaning as port A.
ready_b  output  1  port B ready; combinational.
data_out  output  8 x NUM_OUT (unpacked)  output bytes.
valid_out  output  1 x NUM_OUT (unpacked)  one-cycle strobe per forwarded byte.

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: reg_rdata=0, all data_out=0, all valid_out=0, ready_a=ready_b=0.
  - Registers: CTRL=0, OUT_MASK=4'hF, all counters=0, rr_last=0.
  - Reset mid-transfer discards the in-flight output strobe and clears counters.
- Register map (unlisted addresses read 0; writes to them are ignored):
  - 0x0 CTRL, RW: [0] EN, [1] FIXED_PRI (1 = port A always wins).
  - 0x1 OUT_MASK, RW: [3:0].
  - 0x2 STATUS, RO: [0] rr_last (0=A, 1=B), [1] EN.
  - 0x3 DROP_CNT, RO.
  - 0x4-0x7 FWD_CNT[0..3], RO.
  - 0x8 CLEAR, write-1 pulse: [3:0] clear FWD_CNT[i], [4] clear DROP_CNT. Reads return 0.
  - 0xF ID, RO: 32'h5254_0001, truncated to REG_W.
- Register access timing:
  - Read: reg_rdata updates on the edge where reg_en=1 and reg_we=0; data is visible the next cycle and held until the next read.
  - Write takes effect at the edge where reg_en=1 and reg_we=1.
  - Writes to RO registers are ignored.
- Handshake:
  - A transfer occurs on an edge with valid_x=1 and ready_x=1.
  - ready_x=0 whenever EN=0.
  - If A and B are both valid with different addresses, both are accepted in the same cycle.
- Conflict (both valid, addr_a==addr_b, EN=1):
  - Exactly one ready is high.
  - FIXED_PRI=1: A wins.
  - Otherwise round-robin: the winner is !rr_last, and rr_last updates to the winner. rr_last updates only on conflicts.
  - The loser holds its data; it is accepted in a later cycle.
- Forwarding for an accepted byte with destination d:
  - OUT_MASK[d]=1: on the next edge, data_out[d]=byte, valid_out[d]=1 for one cycle, and FWD_CNT[d]++. Latency is 1 cycle.
  - OUT_MASK[d]=0: the byte is accepted and dropped, DROP_CNT++, no strobe.
  - Two drops in the same cycle add 2 to DROP_CNT.
- Output hold: data_out[i] holds its last value; valid_out is 0 when nothing is forwarded.
- Counters wrap modulo 2^REG_W. A CLEAR in the same cycle as an increment wins (result 0).
- CTRL/OUT_MASK writes affect acceptance from the next cycle onward.

Decomposition:
- Package router_pkg: NUM_OUT, register address localparams, CTRL/CLEAR bit positions, ID constant, and a port-select enum (PORT_A, PORT_B).
- Sub-module router_csr: register decode, counters, reg_rdata. It takes increment/drop pulses from the core datapath and returns EN, FIXED_PRI and OUT_MASK.

Test Plan:
1. Reset, then read 0x1 and 0xF -> reg_rdata=0x0000_000F, then 0x5254_0001, each one cycle after reg_en.
2. EN=1; A sends 0x3C to addr 2 and B sends 0xA5 to addr 1 in the same cycle -> both readys high; next cycle valid_out[2] with 0x3C, valid_out[1] with 0xA5; FWD_CNT[1]=FWD_CNT[2]=1.
3. Round-robin: both ports send to addr 0 for 4 back-to-back cycles -> winners B, A, B, A; data_out[0] alternates accordingly; FWD_CNT[0]=4; FIXED_PRI=1 -> A wins every cycle.
4. OUT_MASK=4'b1110; A sends to addr 0 -> ready_a=1, no valid_out[0], DROP_CNT=1; with EN=0 -> ready_a=ready_b=0.
5. CLEAR=0x01 written in the same cycle as a forward to addr 0 -> FWD_CNT[0] reads 0.
6. rst_n asserted while valid_out[3]=1 -> valid_out[3] drops immediately; all counters read 0 after reset.

Source files
------------

// File: rtl/dual_port_router_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_pkg : shared constants and types for the dual-port byte router
// Rev 1.0
// ---------------------------------------------------------------------------
package router_pkg;

  localparam int NUM_OUT = 4;

  localparam logic [3:0] ADDR_CTRL     = 4'h0;
  localparam logic [3:0] ADDR_OUT_MASK = 4'h1;
  localparam logic [3:0] ADDR_STATUS   = 4'h2;
  localparam logic [3:0] ADDR_DROP_CNT = 4'h3;
  localparam logic [3:0] ADDR_FWD_CNT0 = 4'h4;
  localparam logic [3:0] ADDR_FWD_CNT1 = 4'h5;
  localparam logic [3:0] ADDR_FWD_CNT2 = 4'h6;
  localparam logic [3:0] ADDR_FWD_CNT3 = 4'h7;
  localparam logic [3:0] ADDR_CLEAR    = 4'h8;
  localparam logic [3:0] ADDR_ID       = 4'hF;

  localparam int CTRL_EN_BIT        = 0;
  localparam int CTRL_FIXED_PRI_BIT = 1;
  localparam int CLEAR_DROP_BIT     = 4;

  localparam logic [31:0] ID_VALUE       = 32'h5254_0001;
  localparam logic [3:0]  OUT_MASK_RESET = 4'hF;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_sel_e;

endpackage : router_pkg
`default_nettype wire

// File: rtl/dual_port_router_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dual_port_router_if : register plane, two input ports and the output bank
// Rev 1.0
// ---------------------------------------------------------------------------
interface dual_port_router_if #(
  parameter int REG_W = 32
);
  import router_pkg::*;

  logic [3:0]       reg_addr;
  logic [REG_W-1:0] reg_wdata;
  logic             reg_en;
  logic             reg_we;
  logic [REG_W-1:0] reg_rdata;

  logic [7:0]       data_a;
  logic [1:0]       addr_a;
  logic             valid_a;
  logic             ready_a;

  logic [7:0]       data_b;
  logic [1:0]       addr_b;
  logic             valid_b;
  logic             ready_b;

  logic [7:0]       data_out  [NUM_OUT];
  logic             valid_out [NUM_OUT];

  modport master (
    output reg_addr, reg_wdata, reg_en, reg_we,
    output data_a, addr_a, valid_a,
    output data_b, addr_b, valid_b,
    input  reg_rdata, ready_a, ready_b, data_out, valid_out
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_en, reg_we,
    input  data_a, addr_a, valid_a,
    input  data_b, addr_b, valid_b,
    output reg_rdata, ready_a, ready_b, data_out, valid_out
  );

endinterface : dual_port_router_if
`default_nettype wire

// File: rtl/dual_port_router_csr.sv
`default_nettype none
// ---------------------------------------------------------------------------
// router_csr : control/status registers, forward/drop counters, read port
// Rev 1.0
// ---------------------------------------------------------------------------
module router_csr
  import router_pkg::*;
#(
  parameter int REG_W = 32
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic [3:0]       reg_addr_i,
  input  wire logic [REG_W-1:0] reg_wdata_i,
  input  wire logic             reg_en_i,
  input  wire logic             reg_we_i,
  output logic      [REG_W-1:0] reg_rdata_o,
  input  wire logic [NUM_OUT-1:0] fwd_inc_i,
  input  wire logic [1:0]       drop_inc_i,
  input  port_sel_e             rr_last_i,
  output logic                  en_o,
  output logic                  fixed_pri_o,
  output logic      [NUM_OUT-1:0] out_mask_o
);

  localparam logic [REG_W-1:0] ID_TRUNC = ID_VALUE[REG_W-1:0];

  logic [1:0]         ctrl_q,     ctrl_d;
  logic [NUM_OUT-1:0] mask_q,     mask_d;
  logic [REG_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic [REG_W-1:0]   fwd_cnt_q [NUM_OUT];
  logic [REG_W-1:0]   fwd_cnt_d [NUM_OUT];
  logic [REG_W-1:0]   rdata_q,    rdata_d;

  logic               wr_en;
  logic               rd_en;
  logic [4:0]         clear;
  logic [REG_W-1:0]   rd_val;
  logic               unused_wdata;

  assign unused_wdata = ^reg_wdata_i[REG_W-1:5];

  always_comb begin
    wr_en = reg_en_i & reg_we_i;
    rd_en = reg_en_i & ~reg_we_i;
    clear = (wr_en && reg_addr_i == ADDR_CLEAR) ? reg_wdata_i[4:0] : 5'b0;

    ctrl_d = ctrl_q;
    mask_d = mask_q;
    if (wr_en && reg_addr_i == ADDR_CTRL)     ctrl_d = reg_wdata_i[1:0];
    if (wr_en && reg_addr_i == ADDR_OUT_MASK) mask_d = reg_wdata_i[NUM_OUT-1:0];

    // A clear in the same cycle as an increment takes priority.
    drop_cnt_d = clear[CLEAR_DROP_BIT] ? '0 : drop_cnt_q + REG_W'(drop_inc_i);
    for (int i = 0; i < NUM_OUT; i++) begin
      fwd_cnt_d[i] = clear[i] ? '0 : fwd_cnt_q[i] + REG_W'(fwd_inc_i[i]);
    end

    rd_val = '0;
    case (reg_addr_i)
      ADDR_CTRL:     rd_val[1:0] = ctrl_q;
      ADDR_OUT_MASK: rd_val[NUM_OUT-1:0] = mask_q;
      ADDR_STATUS:   rd_val[1:0] = {ctrl_q[CTRL_EN_BIT], rr_last_i == PORT_B};
      ADDR_DROP_CNT: rd_val = drop_cnt_q;
      ADDR_FWD_CNT0: rd_val = fwd_cnt_q[0];
      ADDR_FWD_CNT1: rd_val = fwd_cnt_q[1];
      ADDR_FWD_CNT2: rd_val = fwd_cnt_q[2];
      ADDR_FWD_CNT3: rd_val = fwd_cnt_q[3];
      ADDR_ID:       rd_val = ID_TRUNC;
      default:       rd_val = '0;
    endcase
    rdata_d = rd_en ? rd_val : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q     <= '0;
      mask_q     <= OUT_MASK_RESET;
      drop_cnt_q <= '0;
      rdata_q    <= '0;
      for (int i = 0; i < NUM_OUT; i++) fwd_cnt_q[i] <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      mask_q     <= mask_d;
      drop_cnt_q <= drop_cnt_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < NUM_OUT; i++) fwd_cnt_q[i] <= fwd_cnt_d[i];
    end
  end

  assign reg_rdata_o = rdata_q;
  assign en_o        = ctrl_q[CTRL_EN_BIT];
  assign fixed_pri_o = ctrl_q[CTRL_FIXED_PRI_BIT];
  assign out_mask_o  = mask_q;

endmodule : router_csr
`default_nettype wire

// File: rtl/dual_port_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// dual_port_router : two valid/ready byte ports routed to four strobed outputs
// Rev 1.0
// ---------------------------------------------------------------------------
module dual_port_router
  import router_pkg::*;
#(
  parameter int REG_W = 32
) (
  input wire logic          clk,
  input wire logic          rst_n,
  dual_port_router_if.slave bus
);

  logic               en;
  logic               fixed_pri;
  logic [NUM_OUT-1:0] out_mask;

  port_sel_e          rr_last_q, rr_last_d;
  logic               conflict;
  logic               a_wins;
  logic               ready_a;
  logic               ready_b;
  logic               acc_a;
  logic               acc_b;
  logic               drop_a;
  logic               drop_b;
  logic [1:0]         drop_inc;
  logic [NUM_OUT-1:0] fwd_a;
  logic [NUM_OUT-1:0] fwd_b;
  logic [NUM_OUT-1:0] fwd_inc;

  logic [7:0]         data_out_q [NUM_OUT];
  logic [7:0]         data_out_d [NUM_OUT];
  logic [NUM_OUT-1:0] valid_out_q, valid_out_d;

  always_comb begin
    conflict = bus.valid_a & bus.valid_b & (bus.addr_a == bus.addr_b);
    // Round-robin: the winner is the port that did not win the last conflict.
    a_wins   = fixed_pri | (rr_last_q == PORT_B);
    ready_a  = en & (~conflict | a_wins);
    ready_b  = en & (~conflict | ~a_wins);
    acc_a    = bus.valid_a & ready_a;
    acc_b    = bus.valid_b & ready_b;

    rr_last_d = rr_last_q;
    if (en && conflict) rr_last_d = a_wins ? PORT_A : PORT_B;

    drop_a   = acc_a & ~out_mask[bus.addr_a];
    drop_b   = acc_b & ~out_mask[bus.addr_b];
    drop_inc = {1'b0, drop_a} + {1'b0, drop_b};

    for (int i = 0; i < NUM_OUT; i++) begin
      fwd_a[i]       = acc_a & (bus.addr_a == 2'(i)) & out_mask[i];
      fwd_b[i]       = acc_b & (bus.addr_b == 2'(i)) & out_mask[i];
      fwd_inc[i]     = fwd_a[i] | fwd_b[i];
      valid_out_d[i] = fwd_inc[i];
      if (fwd_a[i])      data_out_d[i] = bus.data_a;
      else if (fwd_b[i]) data_out_d[i] = bus.data_b;
      else               data_out_d[i] = data_out_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q   <= PORT_A;
      valid_out_q <= '0;
      for (int i = 0; i < NUM_OUT; i++) data_out_q[i] <= 8'h00;
    end else begin
      rr_last_q   <= rr_last_d;
      valid_out_q <= valid_out_d;
      for (int i = 0; i < NUM_OUT; i++) data_out_q[i] <= data_out_d[i];
    end
  end

  router_csr #(
    .REG_W (REG_W)
  ) u_csr (
    .clk         (clk),
    .rst_n       (rst_n),
    .reg_addr_i  (bus.reg_addr),
    .reg_wdata_i (bus.reg_wdata),
    .reg_en_i    (bus.reg_en),
    .reg_we_i    (bus.reg_we),
    .reg_rdata_o (bus.reg_rdata),
    .fwd_inc_i   (fwd_inc),
    .drop_inc_i  (drop_inc),
    .rr_last_i   (rr_last_q),
    .en_o        (en),
    .fixed_pri_o (fixed_pri),
    .out_mask_o  (out_mask)
  );

  assign bus.ready_a = ready_a;
  assign bus.ready_b = ready_b;

  for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_out
    assign bus.data_out[gi]  = data_out_q[gi];
    assign bus.valid_out[gi] = valid_out_q[gi];
  end

endmodule : dual_port_router
`default_nettype wire

// File: tb/tb_dual_port_router.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_dual_port_router : directed vectors with hand-computed expectations
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_dual_port_router;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  dual_port_router_if #(.REG_W(32)) bus ();

  dual_port_router #(.REG_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_wdata = d; bus.reg_en = 1'b1; bus.reg_we = 1'b1;
    @(negedge clk);
    bus.reg_en = 1'b0; bus.reg_we = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.reg_addr = a; bus.reg_en = 1'b1; bus.reg_we = 1'b0;
    @(negedge clk);
    bus.reg_en = 1'b0;
    d = bus.reg_rdata;
  endtask

  task automatic read_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    reg_read(a, d);
    check_eq(tag, d, exp);
  endtask

  task automatic drive_ports(input logic va, input logic [1:0] aa, input logic [7:0] da,
                             input logic vb, input logic [1:0] ab, input logic [7:0] db);
    bus.valid_a = va; bus.addr_a = aa; bus.data_a = da;
    bus.valid_b = vb; bus.addr_b = ab; bus.data_b = db;
  endtask

  // Round-robin and fixed-priority tables; loser keeps presenting its byte.
  logic [7:0] rr_a   [4] = '{8'h11, 8'h11, 8'h12, 8'h12};
  logic [7:0] rr_b   [4] = '{8'h21, 8'h22, 8'h22, 8'h23};
  logic [7:0] rr_out [4] = '{8'h21, 8'h11, 8'h22, 8'h12};
  logic       rr_ra  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  logic       rr_rb  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [7:0] fp_a   [2] = '{8'h13, 8'h14};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_err = 0;
    rst_n = 1'b0;
    bus.reg_addr = '0; bus.reg_wdata = '0; bus.reg_en = 1'b0; bus.reg_we = 1'b0;
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    repeat (2) @(negedge clk);
    check_eq("rst_rdata",  bus.reg_rdata, 32'h0);
    check_eq("rst_ready_a", {31'b0, bus.ready_a}, 32'h0);
    check_eq("rst_vout3",  {31'b0, bus.valid_out[3]}, 32'h0);
    check_eq("rst_dout1",  {24'b0, bus.data_out[1]}, 32'h0);
    rst_n = 1'b1;

    // 1: mask and ID reads
    read_check("rd_mask", 4'h1, 32'h0000_000F);
    read_check("rd_id",   4'hF, 32'h5254_0001);
    read_check("rd_clear_reads0", 4'h8, 32'h0);

    // 2: parallel accept on different outputs
    reg_write(4'h0, 32'h1);
    @(negedge clk);
    drive_ports(1'b1, 2'd2, 8'h3C, 1'b1, 2'd1, 8'hA5);
    #1;
    check_eq("par_ready_a", {31'b0, bus.ready_a}, 32'h1);
    check_eq("par_ready_b", {31'b0, bus.ready_b}, 32'h1);
    @(negedge clk);
    check_eq("par_vout2", {31'b0, bus.valid_out[2]}, 32'h1);
    check_eq("par_dout2", {24'b0, bus.data_out[2]}, 32'h3C);
    check_eq("par_vout1", {31'b0, bus.valid_out[1]}, 32'h1);
    check_eq("par_dout1", {24'b0, bus.data_out[1]}, 32'hA5);
    check_eq("par_vout0", {31'b0, bus.valid_out[0]}, 32'h0);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    check_eq("hold_vout2", {31'b0, bus.valid_out[2]}, 32'h0);
    check_eq("hold_dout2", {24'b0, bus.data_out[2]}, 32'h3C);
    read_check("fwd1_1", 4'h5, 32'h1);
    read_check("fwd2_1", 4'h6, 32'h1);
    read_check("status_en", 4'h2, 32'h2);

    // 3: round-robin conflict on output 0
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        check_eq($sformatf("rr_vout0_%0d", k - 1), {31'b0, bus.valid_out[0]}, 32'h1);
        check_eq($sformatf("rr_dout0_%0d", k - 1), {24'b0, bus.data_out[0]}, {24'b0, rr_out[k-1]});
      end
      drive_ports(1'b1, 2'd0, rr_a[k], 1'b1, 2'd0, rr_b[k]);
      #1;
      check_eq($sformatf("rr_ready_a_%0d", k), {31'b0, bus.ready_a}, {31'b0, rr_ra[k]});
      check_eq($sformatf("rr_ready_b_%0d", k), {31'b0, bus.ready_b}, {31'b0, rr_rb[k]});
    end
    @(negedge clk);
    check_eq("rr_dout0_3", {24'b0, bus.data_out[0]}, {24'b0, rr_out[3]});
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    read_check("fwd0_4", 4'h4, 32'h4);

    // 3b: fixed priority, A wins every cycle
    reg_write(4'h0, 32'h3);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (k > 0) check_eq("fp_dout0_0", {24'b0, bus.data_out[0]}, {24'b0, fp_a[0]});
      drive_ports(1'b1, 2'd0, fp_a[k], 1'b1, 2'd0, 8'h23);
      #1;
      check_eq($sformatf("fp_ready_a_%0d", k), {31'b0, bus.ready_a}, 32'h1);
      check_eq($sformatf("fp_ready_b_%0d", k), {31'b0, bus.ready_b}, 32'h0);
    end
    @(negedge clk);
    check_eq("fp_dout0_1", {24'b0, bus.data_out[0]}, 32'h14);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    read_check("fwd0_6", 4'h4, 32'h6);

    // 4: masked outputs drop bytes
    reg_write(4'h0, 32'h1);
    reg_write(4'h1, 32'hE);
    @(negedge clk);
    drive_ports(1'b1, 2'd0, 8'h55, 1'b0, 2'd0, 8'h00);
    #1;
    check_eq("drop_ready_a", {31'b0, bus.ready_a}, 32'h1);
    @(negedge clk);
    check_eq("drop_vout0", {31'b0, bus.valid_out[0]}, 32'h0);
    check_eq("drop_dout0", {24'b0, bus.data_out[0]}, 32'h14);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    read_check("drop_cnt1", 4'h3, 32'h1);
    reg_write(4'h1, 32'h6);
    @(negedge clk);
    drive_ports(1'b1, 2'd0, 8'h56, 1'b1, 2'd3, 8'h57);
    @(negedge clk);
    check_eq("drop2_vout3", {31'b0, bus.valid_out[3]}, 32'h0);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    read_check("drop_cnt3", 4'h3, 32'h3);
    read_check("fwd3_0", 4'h7, 32'h0);
    reg_write(4'h1, 32'hF);
    reg_write(4'h2, 32'h0);
    read_check("status_ro", 4'h2, 32'h2);

    // 4b: disabled core never asserts ready
    reg_write(4'h0, 32'h0);
    @(negedge clk);
    drive_ports(1'b1, 2'd1, 8'h01, 1'b1, 2'd2, 8'h02);
    #1;
    check_eq("dis_ready_a", {31'b0, bus.ready_a}, 32'h0);
    check_eq("dis_ready_b", {31'b0, bus.ready_b}, 32'h0);
    @(negedge clk);
    check_eq("dis_vout1", {31'b0, bus.valid_out[1]}, 32'h0);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);

    // 5: clear collides with a forward
    reg_write(4'h0, 32'h1);
    @(negedge clk);
    bus.reg_addr = 4'h8; bus.reg_wdata = 32'h1; bus.reg_en = 1'b1; bus.reg_we = 1'b1;
    drive_ports(1'b1, 2'd0, 8'h66, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    bus.reg_en = 1'b0; bus.reg_we = 1'b0;
    check_eq("clr_vout0", {31'b0, bus.valid_out[0]}, 32'h1);
    check_eq("clr_dout0", {24'b0, bus.data_out[0]}, 32'h66);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    read_check("clr_fwd0", 4'h4, 32'h0);
    read_check("clr_fwd1_kept", 4'h5, 32'h1);

    // 6: asynchronous reset during an output strobe
    @(negedge clk);
    drive_ports(1'b1, 2'd3, 8'h77, 1'b0, 2'd0, 8'h00);
    @(negedge clk);
    drive_ports(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00);
    check_eq("pre_rst_vout3", {31'b0, bus.valid_out[3]}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_vout3", {31'b0, bus.valid_out[3]}, 32'h0);
    check_eq("arst_dout3", {24'b0, bus.data_out[3]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    read_check("post_rst_drop", 4'h3, 32'h0);
    read_check("post_rst_fwd1", 4'h5, 32'h0);
    read_check("post_rst_fwd3", 4'h7, 32'h0);
    read_check("post_rst_ctrl", 4'h0, 32'h0);
    read_check("post_rst_mask", 4'h1, 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_dual_port_router
`default_nettype wire
